gmii_tx: RTL

GMII transmit framer: accepts an Ethernet frame (destination MAC through payload) as a byte stream and drives the 8-bit GMII transmit pins at 125 MHz. It adds preamble and SFD, zero-pads to the minimum length, appends the IEEE 802.3 FCS and enforces the inter-frame gap. It is the transmit-side counterpart of gmii_rx inside mac_phy; mac_phy drives TX_CLK from CLK.

---
 rtl/gmii_pkg.sv | 26 ++
 rtl/crc32_d8.sv | 23 ++
 rtl/gmii_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gmii_pkg.sv
// gmii_pkg: shared constants and FSM state type for the GMII framer and its rx counterpart.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left after running the CRC over data followed by its own FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        ERR,
        DROP,
        IFG
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: reflected CRC-32 advanced by one byte, LSB of the byte first.
// Latency: combinational.
// Backpressure: none; the caller decides when to register crc_next.
// Ports: crc = current register, data = byte to absorb, crc_next = updated register.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ (c[0] ? CRC32_POLY : 32'h00000000);
        end
        crc_next = c;
    end

endmodule

// File: rtl/gmii_tx.sv
// gmii_tx: GMII transmit framer adding preamble/SFD, zero pad, FCS and inter-frame gap.
// Latency: byte accepted in cycle k is on TX_D in cycle k+1; SFD is on the wire 8 cycles after start.
// Backpressure: o_ready only in SFD/DATA (until i_last) and DROP; a bubble while ready in SFD/DATA aborts.
// Ports: CLK/RST clock and async active-high reset; i_valid/i_data/i_last/o_ready input byte stream;
//        TX_D/TX_EN/TX_ERR registered GMII pins; o_busy (not IDLE), o_frame_done (last FCS byte),
//        o_underrun (error cycle), o_byte_cnt (data+pad count of the last good frame).
module gmii_tx
    import gmii_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int IFG_LEN = 12,
    parameter int PRE_LEN = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic        o_ready,
    output logic [7:0]  TX_D,
    output logic        TX_EN,
    output logic        TX_ERR,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_underrun,
    output logic [10:0] o_byte_cnt
);

    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX   = 11'h7FF;

    tx_state_t   state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [10:0] len_cnt, len_cnt_nxt, len_inc;
    logic [31:0] crc, crc_nxt, crc_upd, fcs;
    logic [7:0]  crc_byte;

    logic [7:0]  tx_d_nxt;
    logic        tx_en_nxt;
    logic        tx_err_nxt;
    logic        done_nxt;
    logic        underrun_nxt;
    logic [10:0] byte_cnt_nxt;

    // Pad bytes are zero; everything else the CRC sees comes from the stream.
    assign crc_byte = (state == PAD) ? 8'h00 : i_data;

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .crc_next (crc_upd)
    );

    assign len_inc = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + 11'd1;
    assign fcs     = ~crc;

    assign o_busy  = (state != IDLE);
    assign o_ready = (state == SFD) || (state == DATA) || (state == DROP);

    // The state in a cycle decides what goes on the wire in the following cycle,
    // so each branch computes the next registered pin values.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        len_cnt_nxt  = len_cnt;
        crc_nxt      = crc;
        tx_d_nxt     = 8'h00;
        tx_en_nxt    = 1'b0;
        tx_err_nxt   = 1'b0;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        byte_cnt_nxt = o_byte_cnt;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                len_cnt_nxt = '0;
                crc_nxt     = CRC32_INIT;
                if (i_valid) begin
                    state_nxt = PRE;
                    tx_en_nxt = 1'b1;
                    tx_d_nxt  = PREAMBLE_BYTE;
                end
            end

            // The IDLE edge already launched the first 0x55; the last PRE cycle launches the SFD.
            PRE: begin
                tx_en_nxt = 1'b1;
                if (cnt == 8'(PRE_LEN - 1)) begin
                    tx_d_nxt  = SFD_BYTE;
                    state_nxt = SFD;
                    cnt_nxt   = '0;
                end else begin
                    tx_d_nxt = PREAMBLE_BYTE;
                    cnt_nxt  = cnt + 8'd1;
                end
            end

            SFD, DATA: begin
                tx_en_nxt = 1'b1;
                cnt_nxt   = '0;
                if (i_valid) begin
                    tx_d_nxt    = i_data;
                    crc_nxt     = crc_upd;
                    len_cnt_nxt = len_inc;
                    if (i_last) begin
                        state_nxt = (len_inc < MIN_LEN_C) ? PAD : FCS;
                    end else begin
                        state_nxt = DATA;
                    end
                end else begin
                    tx_err_nxt   = 1'b1;
                    underrun_nxt = 1'b1;
                    state_nxt    = ERR;
                end
            end

            PAD: begin
                tx_en_nxt   = 1'b1;
                crc_nxt     = crc_upd;
                len_cnt_nxt = len_inc;
                cnt_nxt     = '0;
                if (len_inc >= MIN_LEN_C) begin
                    state_nxt = FCS;
                end
            end

            FCS: begin
                tx_en_nxt = 1'b1;
                case (cnt[1:0])
                    2'd0:    tx_d_nxt = fcs[7:0];
                    2'd1:    tx_d_nxt = fcs[15:8];
                    2'd2:    tx_d_nxt = fcs[23:16];
                    default: tx_d_nxt = fcs[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    done_nxt     = 1'b1;
                    byte_cnt_nxt = len_cnt;
                    state_nxt    = IFG;
                    cnt_nxt      = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            ERR: begin
                state_nxt = DROP;
            end

            DROP: begin
                cnt_nxt = '0;
                if (i_valid && i_last) begin
                    state_nxt = IFG;
                end
            end

            // IFG_LEN+1 cycles here: the first still carries the last FCS byte,
            // leaving IFG_LEN low cycles before IDLE plus the IDLE decision cycle.
            IFG: begin
                if (cnt == 8'(IFG_LEN)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            len_cnt      <= '0;
            crc          <= CRC32_INIT;
            TX_D         <= 8'h00;
            TX_EN        <= 1'b0;
            TX_ERR       <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
            o_byte_cnt   <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            len_cnt      <= len_cnt_nxt;
            crc          <= crc_nxt;
            TX_D         <= tx_d_nxt;
            TX_EN        <= tx_en_nxt;
            TX_ERR       <= tx_err_nxt;
            o_frame_done <= done_nxt;
            o_underrun   <= underrun_nxt;
            o_byte_cnt   <= byte_cnt_nxt;
        end
    end

endmodule
